// File: rtl/riscv_csr_access_ctrl_pkg.sv
// Shared CSR constants, opcode and FSM state encodings for the CSR access controller.
// Package riscv_constants; consumers use import riscv_constants::*.
package riscv_constants;

   typedef enum logic [2:0] {
      CSR_OP_NONE = 3'b000,
      CSR_OP_RW   = 3'b001,
      CSR_OP_RS   = 3'b010,
      CSR_OP_RC   = 3'b011,
      CSR_OP_RSV  = 3'b100,
      CSR_OP_RWI  = 3'b101,
      CSR_OP_RSI  = 3'b110,
      CSR_OP_RCI  = 3'b111
   } csr_op_e;

   localparam logic [11:0] CSR_MTVEC    = 12'h305;
   localparam logic [11:0] CSR_MEPC     = 12'h341;
   localparam logic [11:0] CSR_MCAUSE   = 12'h342;
   localparam logic [11:0] MRET_FUNCT12 = 12'h302;

   localparam int ECALL_M = 11;

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_RESP,
      S_T_EPC,
      S_T_CAUSE,
      S_T_VEC,
      S_T_RET
   } csr_state_e;

   // The top two address bits equal to 2'b11 mark the read-only CSR space.
   function automatic logic csr_is_read_only(input logic [11:0] addr);
      return (addr[11:10] == 2'b11);
   endfunction

endpackage

// File: rtl/riscv_csr_access_ctrl_alu.sv
// Combinational read-modify-write datapath: computes the new CSR value and
// whether the instruction actually writes, flagging reserved opcodes.
module riscv_csr_alu
   import riscv_constants::*;
#(
   parameter int WORD_LENGTH = 32
) (
   input  csr_op_e                op,
   input  logic [WORD_LENGTH-1:0] old_value,
   input  logic [WORD_LENGTH-1:0] src,
   input  logic                   src_nz,
   output logic [WORD_LENGTH-1:0] new_value,
   output logic                   write_needed,
   output logic                   illegal
);

   logic [WORD_LENGTH-1:0] set_bits;
   logic [WORD_LENGTH-1:0] clr_bits;

   genvar gi;
   generate
      for (gi = 0; gi < WORD_LENGTH; gi++) begin : g_bit
         assign set_bits[gi] = old_value[gi] | src[gi];
         assign clr_bits[gi] = old_value[gi] & ~src[gi];
      end
   endgenerate

   always_comb begin
      new_value    = old_value;
      write_needed = 1'b0;
      illegal      = 1'b0;
      case (op)
         CSR_OP_RW, CSR_OP_RWI: begin
            new_value    = src;
            write_needed = 1'b1;
         end
         // Set/clear forms with a zero source are pure reads.
         CSR_OP_RS, CSR_OP_RSI: begin
            new_value    = set_bits;
            write_needed = src_nz;
         end
         CSR_OP_RC, CSR_OP_RCI: begin
            new_value    = clr_bits;
            write_needed = src_nz;
         end
         default: begin
            illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/riscv_csr_access_ctrl.sv
// Sequences CSR read/modify/write and ECALL trap entry onto the CSR register file.
// Optional RISCV_CSR_MRET_EN adds MRET decode (op 000, addr 0x302) returning mepc as a redirect.
module riscv_csr_access_ctrl
   import riscv_constants::*;
#(
   parameter int WORD_LENGTH = 32,
   parameter int ADDR_W      = 12
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [2:0]             req_op,
   input  logic                   req_ecall,
   input  logic [ADDR_W-1:0]      req_addr,
   input  logic [WORD_LENGTH-1:0] req_src,
   input  logic                   req_src_nz,
   input  logic [WORD_LENGTH-1:0] req_pc,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WORD_LENGTH-1:0] rsp_rdata,
   output logic                   rsp_redirect,
   output logic [WORD_LENGTH-1:0] rsp_target,
   output logic                   rsp_illegal,
   output logic                   csr_we,
   output logic [WORD_LENGTH-1:0] csr_addr,
   output logic [WORD_LENGTH-1:0] csr_wdata,
   input  logic [WORD_LENGTH-1:0] csr_rdata
);

   csr_state_e             state_reg;
   logic                   req_ready_reg;
   csr_op_e                op_reg;
   logic [ADDR_W-1:0]      addr_reg;
   logic [WORD_LENGTH-1:0] src_reg;
   logic                   src_nz_reg;

   logic                   rsp_valid_reg;
   logic [WORD_LENGTH-1:0] rsp_rdata_reg;
   logic                   rsp_redirect_reg;
   logic [WORD_LENGTH-1:0] rsp_target_reg;
   logic                   rsp_illegal_reg;
   logic                   csr_we_reg;
   logic [WORD_LENGTH-1:0] csr_addr_reg;
   logic [WORD_LENGTH-1:0] csr_wdata_reg;

   logic [WORD_LENGTH-1:0] alu_new;
   logic                   alu_write_needed;
   logic                   alu_illegal;
   logic                   illegal_full;
   logic                   accept;
   logic                   is_mret;

   riscv_csr_alu #(
      .WORD_LENGTH (WORD_LENGTH)
   ) u_alu (
      .op           (op_reg),
      .old_value    (csr_rdata),
      .src          (src_reg),
      .src_nz       (src_nz_reg),
      .new_value    (alu_new),
      .write_needed (alu_write_needed),
      .illegal      (alu_illegal)
   );

   assign accept = req_valid && req_ready_reg;

`ifdef RISCV_CSR_MRET_EN
   assign is_mret = (req_op == 3'b000) && !req_ecall && (req_addr == ADDR_W'(MRET_FUNCT12));
`else
   assign is_mret = 1'b0;
`endif

   // A write into read-only space is only an error if a write would actually happen.
   assign illegal_full = alu_illegal ||
                         (alu_write_needed && csr_is_read_only(addr_reg[11:0]));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg        <= S_IDLE;
         req_ready_reg    <= 1'b0;
         op_reg           <= CSR_OP_NONE;
         addr_reg         <= '0;
         src_reg          <= '0;
         src_nz_reg       <= 1'b0;
         rsp_valid_reg    <= 1'b0;
         rsp_rdata_reg    <= '0;
         rsp_redirect_reg <= 1'b0;
         rsp_target_reg   <= '0;
         rsp_illegal_reg  <= 1'b0;
         csr_we_reg       <= 1'b0;
         csr_addr_reg     <= '0;
         csr_wdata_reg    <= '0;
      end else begin
         csr_we_reg <= 1'b0;
         case (state_reg)
            S_IDLE: begin
               if (accept) begin
                  req_ready_reg <= 1'b0;
                  op_reg        <= csr_op_e'(req_op);
                  addr_reg      <= req_addr;
                  src_reg       <= req_src;
                  src_nz_reg    <= req_src_nz;
                  if (req_ecall) begin
                     state_reg     <= S_T_EPC;
                     csr_addr_reg  <= WORD_LENGTH'(CSR_MEPC);
                     csr_wdata_reg <= req_pc;
                     csr_we_reg    <= 1'b1;
                  end else if (is_mret) begin
                     state_reg    <= S_T_RET;
                     csr_addr_reg <= WORD_LENGTH'(CSR_MEPC);
                  end else begin
                     state_reg    <= S_READ;
                     csr_addr_reg <= WORD_LENGTH'(req_addr);
                  end
               end else begin
                  req_ready_reg <= 1'b1;
               end
            end
            // Old value and the write beat are both taken from this cycle's read data.
            S_READ: begin
               state_reg        <= S_WRITE;
               rsp_rdata_reg    <= csr_rdata;
               rsp_illegal_reg  <= illegal_full;
               rsp_redirect_reg <= 1'b0;
               rsp_target_reg   <= '0;
               csr_wdata_reg    <= alu_new;
               csr_we_reg       <= alu_write_needed && !illegal_full;
            end
            S_WRITE: begin
               state_reg     <= S_RESP;
               rsp_valid_reg <= 1'b1;
            end
            S_T_EPC: begin
               state_reg     <= S_T_CAUSE;
               csr_addr_reg  <= WORD_LENGTH'(CSR_MCAUSE);
               csr_wdata_reg <= WORD_LENGTH'(ECALL_M);
               csr_we_reg    <= 1'b1;
            end
            S_T_CAUSE: begin
               state_reg     <= S_T_VEC;
               csr_addr_reg  <= WORD_LENGTH'(CSR_MTVEC);
               csr_wdata_reg <= '0;
            end
            // Direct mode only: mode bits of mtvec are dropped from the target.
            S_T_VEC: begin
               state_reg        <= S_RESP;
               rsp_valid_reg    <= 1'b1;
               rsp_rdata_reg    <= '0;
               rsp_redirect_reg <= 1'b1;
               rsp_target_reg   <= {csr_rdata[WORD_LENGTH-1:2], 2'b00};
               rsp_illegal_reg  <= 1'b0;
            end
            S_T_RET: begin
               state_reg        <= S_RESP;
               rsp_valid_reg    <= 1'b1;
               rsp_rdata_reg    <= '0;
               rsp_redirect_reg <= 1'b1;
               rsp_target_reg   <= csr_rdata;
               rsp_illegal_reg  <= 1'b0;
            end
            S_RESP: begin
               if (rsp_ready) begin
                  state_reg     <= S_IDLE;
                  rsp_valid_reg <= 1'b0;
                  req_ready_reg <= 1'b1;
               end
            end
            default: begin
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   assign req_ready    = req_ready_reg;
   assign rsp_valid    = rsp_valid_reg;
   assign rsp_rdata    = rsp_rdata_reg;
   assign rsp_redirect = rsp_redirect_reg;
   assign rsp_target   = rsp_target_reg;
   assign rsp_illegal  = rsp_illegal_reg;
   assign csr_we       = csr_we_reg;
   assign csr_addr     = csr_addr_reg;
   assign csr_wdata    = csr_wdata_reg;

endmodule

// File: tb/tb_riscv_csr_access_ctrl.sv
// Scoreboard bench for riscv_csr_access_ctrl: driver queues expected writes and
// responses, a negedge monitor compares CSR-file writes and responses as they appear.
module tb_riscv_csr_access_ctrl;

   typedef struct {
      logic [31:0] rdata;
      logic        redirect;
      logic [31:0] target;
      logic        illegal;
      int          lat;
      int          acc;
   } rsp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic        clk;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  req_op;
   logic        req_ecall;
   logic [11:0] req_addr;
   logic [31:0] req_src;
   logic        req_src_nz;
   logic [31:0] req_pc;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_redirect;
   logic [31:0] rsp_target;
   logic        rsp_illegal;
   logic        csr_we;
   logic [31:0] csr_addr;
   logic [31:0] csr_wdata;
   logic [31:0] csr_rdata;

   logic [31:0] mem [0:4095];
   rsp_t        rsp_q[$];
   wr_t         wr_q[$];
   int          tests;
   int          fails;
   int          cyc;
   logic        prev_valid;

   riscv_csr_access_ctrl #(
      .WORD_LENGTH (32),
      .ADDR_W      (12)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_op       (req_op),
      .req_ecall    (req_ecall),
      .req_addr     (req_addr),
      .req_src      (req_src),
      .req_src_nz   (req_src_nz),
      .req_pc       (req_pc),
      .rsp_valid    (rsp_valid),
      .rsp_ready    (rsp_ready),
      .rsp_rdata    (rsp_rdata),
      .rsp_redirect (rsp_redirect),
      .rsp_target   (rsp_target),
      .rsp_illegal  (rsp_illegal),
      .csr_we       (csr_we),
      .csr_addr     (csr_addr),
      .csr_wdata    (csr_wdata),
      .csr_rdata    (csr_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign csr_rdata = mem[csr_addr[11:0]];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (csr_we) mem[csr_addr[11:0]] = csr_wdata;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests = tests + 1;
      if (act !== exp) begin
         fails = fails + 1;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      tests = tests + 1;
      fails = fails + 1;
      $display("FAIL %s: got event expected none/timely", name);
   endtask

   function automatic rsp_t mk(input logic [31:0] rdata, input logic redir,
                               input logic [31:0] target, input logic ill, input int lat);
      rsp_t r;
      r.rdata = rdata; r.redirect = redir; r.target = target;
      r.illegal = ill; r.lat = lat; r.acc = 0;
      return r;
   endfunction

   task automatic push_wr(input logic [31:0] a, input logic [31:0] d);
      wr_t w;
      w.addr = a; w.data = d;
      wr_q.push_back(w);
   endtask

   // Monitor: compares every CSR write and every response against the queues.
   always @(negedge clk) begin
      rsp_t e;
      wr_t  w;
      if (rst) begin
         prev_valid = 1'b0;
      end else begin
         if (csr_we) begin
            if (wr_q.size() == 0) fail_now("unexpected_csr_write");
            else begin
               w = wr_q.pop_front();
               chk("wr_addr", csr_addr, w.addr);
               chk("wr_data", csr_wdata, w.data);
               $display("[TB] write addr=%h data=%h", csr_addr, csr_wdata);
            end
         end
         if (rsp_valid && !prev_valid) begin
            if (rsp_q.size() == 0) fail_now("unexpected_response");
            else chk("latency", 32'(cyc - rsp_q[0].acc), 32'(rsp_q[0].lat));
         end
         if (rsp_valid && rsp_q.size() > 0) begin
            e = rsp_q[0];
            chk("rsp_rdata", rsp_rdata, e.rdata);
            chk("rsp_redirect", 32'(rsp_redirect), 32'(e.redirect));
            chk("rsp_target", rsp_target, e.target);
            chk("rsp_illegal", 32'(rsp_illegal), 32'(e.illegal));
            chk("req_ready_busy", 32'(req_ready), 32'd0);
            if (rsp_ready) begin
               void'(rsp_q.pop_front());
               $display("[TB] response rdata=%h redirect=%0d target=%h illegal=%0d",
                        rsp_rdata, rsp_redirect, rsp_target, rsp_illegal);
            end
         end
         prev_valid = rsp_valid;
      end
   end

   // Called at posedge+1; returns at posedge+1 after the accept edge.
   task automatic issue(input logic [2:0] op, input logic ecall, input logic [11:0] addr,
                        input logic [31:0] src, input logic nz, input logic [31:0] pc,
                        input rsp_t exp, input int stall);
      int   n;
      rsp_t e;
      rsp_ready  = (stall == 0);
      req_valid  = 1'b1;
      req_op     = op;
      req_ecall  = ecall;
      req_addr   = addr;
      req_src    = src;
      req_src_nz = nz;
      req_pc     = pc;
      n = 0;
      while (!req_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         fail_now("req_ready_timeout");
         req_valid = 1'b0;
         return;
      end
      e = exp;
      e.acc = cyc;
      rsp_q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (stall > 0) begin
         n = 0;
         while (!rsp_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
         end
         rsp_ready = 1'b1;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((rsp_q.size() != 0 || wr_q.size() != 0 || rsp_valid) && n < 60) begin
         @(posedge clk); #1;
         n++;
      end
      if (rsp_q.size() != 0 || wr_q.size() != 0) begin
         fail_now("completion_timeout");
         rsp_q.delete();
         wr_q.delete();
      end
   endtask

   initial begin
      tests = 0; fails = 0; cyc = 0; prev_valid = 1'b0;
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      rst = 1'b1; req_valid = 1'b0; req_op = 3'b0; req_ecall = 1'b0;
      req_addr = 12'h0; req_src = 32'h0; req_src_nz = 1'b0; req_pc = 32'h0; rsp_ready = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'h0);
      chk("rst_rsp_redirect", 32'(rsp_redirect), 32'd0);
      chk("rst_rsp_target", rsp_target, 32'h0);
      chk("rst_rsp_illegal", 32'(rsp_illegal), 32'd0);
      chk("rst_csr_we", 32'(csr_we), 32'd0);
      chk("rst_csr_addr", csr_addr, 32'h0);
      chk("rst_csr_wdata", csr_wdata, 32'h0);
      rst = 1'b0;
      @(posedge clk); #1;

      // CSRRW
      mem[12'h300] = 32'h1;
      push_wr(32'h300, 32'hDEADBEEF);
      issue(3'b001, 1'b0, 12'h300, 32'hDEADBEEF, 1'b1, 32'h0, mk(32'h1, 1'b0, 32'h0, 1'b0, 3), 0);
      wait_idle();

      // CSRRS, then CSRRS with zero source
      mem[12'h300] = 32'h0F;
      push_wr(32'h300, 32'hFF);
      issue(3'b010, 1'b0, 12'h300, 32'hF0, 1'b1, 32'h0, mk(32'h0F, 1'b0, 32'h0, 1'b0, 3), 0);
      wait_idle();
      issue(3'b010, 1'b0, 12'h300, 32'h0, 1'b0, 32'h0, mk(32'hFF, 1'b0, 32'h0, 1'b0, 3), 0);
      wait_idle();

      // CSRRCI, then reserved op 100
      push_wr(32'h300, 32'hFC);
      issue(3'b111, 1'b0, 12'h300, 32'h3, 1'b1, 32'h0, mk(32'hFF, 1'b0, 32'h0, 1'b0, 3), 0);
      wait_idle();
      issue(3'b100, 1'b0, 12'h300, 32'h7, 1'b1, 32'h0, mk(32'hFC, 1'b0, 32'h0, 1'b1, 3), 0);
      wait_idle();

      // ECALL
      mem[12'h305] = 32'h2001;
      push_wr(32'h341, 32'h100);
      push_wr(32'h342, 32'd11);
      issue(3'b000, 1'b1, 12'h0, 32'h0, 1'b0, 32'h100, mk(32'h0, 1'b1, 32'h2000, 1'b0, 4), 0);
      wait_idle();

      // Read-only space: write attempt illegal, pure read legal
      mem[12'hC00] = 32'h55;
      issue(3'b001, 1'b0, 12'hC00, 32'h9, 1'b1, 32'h0, mk(32'h55, 1'b0, 32'h0, 1'b1, 3), 0);
      wait_idle();
      issue(3'b010, 1'b0, 12'hC00, 32'h0, 1'b0, 32'h0, mk(32'h55, 1'b0, 32'h0, 1'b0, 3), 0);
      wait_idle();

      // Response back-pressure for 5 cycles
      mem[12'h340] = 32'h7;
      push_wr(32'h340, 32'h5);
      issue(3'b101, 1'b0, 12'h340, 32'h5, 1'b1, 32'h0, mk(32'h7, 1'b0, 32'h0, 1'b0, 3), 5);
      wait_idle();

      // MRET encoding
      mem[12'h341] = 32'h104;
      mem[12'h302] = 32'h1800;
`ifdef RISCV_CSR_MRET_EN
      issue(3'b000, 1'b0, 12'h302, 32'h0, 1'b0, 32'h0, mk(32'h0, 1'b1, 32'h104, 1'b0, 2), 0);
`else
      issue(3'b000, 1'b0, 12'h302, 32'h0, 1'b0, 32'h0, mk(32'h1800, 1'b0, 32'h0, 1'b1, 3), 0);
`endif
      wait_idle();
      chk("mret_mepc_kept", mem[12'h341], 32'h104);

      // Back-to-back CSRRC then CSRRS
      push_wr(32'h300, 32'hF0);
      push_wr(32'h300, 32'hF1);
      issue(3'b011, 1'b0, 12'h300, 32'h0C, 1'b1, 32'h0, mk(32'hFC, 1'b0, 32'h0, 1'b0, 3), 0);
      issue(3'b010, 1'b0, 12'h300, 32'h01, 1'b1, 32'h0, mk(32'hF0, 1'b0, 32'h0, 1'b0, 3), 0);
      wait_idle();

      // Reset asserted in WRITE aborts the write
      mem[12'h300] = 32'h1234;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 3'b001; req_ecall = 1'b0; req_addr = 12'h300;
      req_src = 32'hAAAA; req_src_nz = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("abort_csr_we", 32'(csr_we), 32'd0);
      chk("abort_csr_addr", csr_addr, 32'h0);
      chk("abort_csr_wdata", csr_wdata, 32'h0);
      chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("abort_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("abort_no_write", mem[12'h300], 32'h1234);
      $display("[TB] reset abort checked mem=%h", mem[12'h300]);

      // Recovery after abort
      push_wr(32'h300, 32'h5678);
      issue(3'b001, 1'b0, 12'h300, 32'h5678, 1'b1, 32'h0, mk(32'h1234, 1'b0, 32'h0, 1'b0, 3), 0);
      wait_idle();

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
